// File: rtl/moka_rv32i_sc_trace_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : moka_rv32i_sc_trace_fifo_if
// Brief    : Retire-side and trace-side bus of the RV32I single-cycle trace FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface moka_rv32i_sc_trace_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  retire_valid;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instruction;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] WD3;
    logic                  RegWrite;
    logic                  MemWrite;
    logic [DATA_WIDTH-1:0] ALUResult;
    logic [DATA_WIDTH-1:0] RD2;

    logic                  trace_valid;
    logic                  trace_ready;
    logic [DATA_WIDTH-1:0] tr_pc;
    logic [DATA_WIDTH-1:0] tr_instr;
    logic [4:0]            tr_rd;
    logic [DATA_WIDTH-1:0] tr_wd;
    logic                  tr_regwrite;
    logic                  tr_memwrite;
    logic [DATA_WIDTH-1:0] tr_maddr;
    logic [DATA_WIDTH-1:0] tr_mdata;

    // Core plus trace consumer side.
    modport master (
        output retire_valid, pc, instruction, rd, WD3, RegWrite, MemWrite, ALUResult, RD2,
        output trace_ready,
        input  trace_valid, tr_pc, tr_instr, tr_rd, tr_wd, tr_regwrite, tr_memwrite,
        input  tr_maddr, tr_mdata
    );

    // FIFO side.
    modport slave (
        input  retire_valid, pc, instruction, rd, WD3, RegWrite, MemWrite, ALUResult, RD2,
        input  trace_ready,
        output trace_valid, tr_pc, tr_instr, tr_rd, tr_wd, tr_regwrite, tr_memwrite,
        output tr_maddr, tr_mdata
    );
endinterface
`default_nettype wire

// File: rtl/moka_rv32i_sc_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : moka_rv32i_sc_trace_fifo
// Brief    : Retirement trace FIFO with drop counting; store fields are kept
//            only when MOKA_TRACE_MEM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module moka_rv32i_sc_trace_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    moka_rv32i_sc_trace_fifo_if.slave bus,
    output logic [$clog2(DEPTH):0]  level,
    output logic [31:0]             retired_cnt,
    output logic [15:0]             drop_cnt,
    output logic                    overflow
);
    localparam int              c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = DEPTH[c_AW:0];

    logic [c_AW-1:0]       r_wptr;
    logic [c_AW-1:0]       r_rptr;
    logic [c_AW:0]         r_level;
    logic [31:0]           r_retired_cnt;
    logic [15:0]           r_drop_cnt;
    logic                  r_overflow;

    logic [DATA_WIDTH-1:0] r_pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0] r_instr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_wd_mem    [DEPTH];
    logic [4:0]            r_rd_mem    [DEPTH];
    logic                  r_rw_mem    [DEPTH];
    logic                  r_mw_mem    [DEPTH];

    logic                  w_nonempty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_wr;
    logic                  w_rw;
    logic [DATA_WIDTH-1:0] w_maddr;
    logic [DATA_WIDTH-1:0] w_mdata;

    assign w_nonempty = (r_level != '0);
    assign w_full     = (r_level == c_FULL);
    assign w_pop      = w_nonempty & bus.trace_ready;
    assign w_push     = bus.retire_valid & (~w_full | w_pop);
    assign w_drop     = bus.retire_valid & w_full & ~w_pop;
    assign w_wr       = w_push & ~clr;
    assign w_rw       = bus.RegWrite & (bus.rd != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_level       <= '0;
            r_retired_cnt <= '0;
            r_drop_cnt    <= '0;
            r_overflow    <= 1'b0;
        end else if (clr) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_level       <= '0;
            r_retired_cnt <= '0;
            r_drop_cnt    <= '0;
            r_overflow    <= 1'b0;
        end else begin
            // Pointers are exactly c_AW bits wide, so they wrap at DEPTH.
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (bus.retire_valid) r_retired_cnt <= r_retired_cnt + 32'd1;
            if (w_drop) begin
                if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
                r_overflow <= 1'b1;
            end
        end
    end

    // Record storage carries no reset; validity is tracked by r_level alone.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_pc_mem[r_wptr]    <= bus.pc;
            r_instr_mem[r_wptr] <= bus.instruction;
            r_rd_mem[r_wptr]    <= bus.rd;
            r_rw_mem[r_wptr]    <= w_rw;
            r_wd_mem[r_wptr]    <= w_rw ? bus.WD3 : '0;
            r_mw_mem[r_wptr]    <= bus.MemWrite;
        end
    end

`ifdef MOKA_TRACE_MEM_EN
    logic [DATA_WIDTH-1:0] r_maddr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_mdata_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_maddr_mem[r_wptr] <= bus.MemWrite ? bus.ALUResult : '0;
            r_mdata_mem[r_wptr] <= bus.MemWrite ? bus.RD2 : '0;
        end
    end

    assign w_maddr = r_maddr_mem[r_rptr];
    assign w_mdata = r_mdata_mem[r_rptr];
`else
    logic w_unused_mem;
    assign w_unused_mem = ^{bus.ALUResult, bus.RD2};
    assign w_maddr      = '0;
    assign w_mdata      = '0;
`endif

    // Head record is forced to zero whenever the FIFO is empty.
    assign bus.trace_valid = w_nonempty;
    assign bus.tr_pc       = w_nonempty ? r_pc_mem[r_rptr]    : '0;
    assign bus.tr_instr    = w_nonempty ? r_instr_mem[r_rptr] : '0;
    assign bus.tr_rd       = w_nonempty ? r_rd_mem[r_rptr]    : 5'd0;
    assign bus.tr_wd       = w_nonempty ? r_wd_mem[r_rptr]    : '0;
    assign bus.tr_regwrite = w_nonempty & r_rw_mem[r_rptr];
    assign bus.tr_memwrite = w_nonempty & r_mw_mem[r_rptr];
    assign bus.tr_maddr    = w_nonempty ? w_maddr : '0;
    assign bus.tr_mdata    = w_nonempty ? w_mdata : '0;

    assign level       = r_level;
    assign retired_cnt = r_retired_cnt;
    assign drop_cnt    = r_drop_cnt;
    assign overflow    = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_moka_rv32i_sc_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_moka_rv32i_sc_trace_fifo
// Brief    : Directed self-checking bench for the retirement trace FIFO
//            (store-field expectations follow MOKA_TRACE_MEM_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_moka_rv32i_sc_trace_fifo;
    localparam int c_DW    = 32;
    localparam int c_DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [3:0]  level;
    logic [31:0] retired_cnt;
    logic [15:0] drop_cnt;
    logic        overflow;

    int n_checks;
    int n_fail;

`ifdef MOKA_TRACE_MEM_EN
    localparam logic [31:0] c_EXP_MADDR = 32'h0000_2000;
    localparam logic [31:0] c_EXP_MDATA = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] c_EXP_MADDR = 32'h0;
    localparam logic [31:0] c_EXP_MDATA = 32'h0;
`endif

    moka_rv32i_sc_trace_fifo_if #(.DATA_WIDTH(c_DW)) bus ();

    moka_rv32i_sc_trace_fifo #(
        .DATA_WIDTH (c_DW),
        .DEPTH      (c_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .bus         (bus),
        .level       (level),
        .retired_cnt (retired_cnt),
        .drop_cnt    (drop_cnt),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] p, input logic [31:0] ins, input logic [4:0] r,
                         input logic [31:0] wd, input logic rw, input logic mw,
                         input logic [31:0] addr, input logic [31:0] data);
        bus.retire_valid = 1'b1;
        bus.pc           = p;
        bus.instruction  = ins;
        bus.rd           = r;
        bus.WD3          = wd;
        bus.RegWrite     = rw;
        bus.MemWrite     = mw;
        bus.ALUResult    = addr;
        bus.RD2          = data;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        clr      = 1'b0;
        bus.trace_ready = 1'b0;
        drive(32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.retire_valid = 1'b0;
        #22;
        check("rst_level",   level, 0);
        check("rst_valid",   bus.trace_valid, 0);
        check("rst_tr_pc",   bus.tr_pc, 0);
        check("rst_retired", retired_cnt, 0);
        check("rst_drop",    drop_cnt, 0);
        check("rst_ovf",     overflow, 0);

        // Single record, pushed on the very first edge after reset release
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h10, 32'h0050_0093, 5'd1, 32'd5, 1'b1, 1'b0, 32'h0, 32'h0);
        check("no_bypass", bus.trace_valid, 0);
        step();
        bus.retire_valid = 1'b0;
        check("s_valid",   bus.trace_valid, 1);
        check("s_pc",      bus.tr_pc, 32'h10);
        check("s_instr",   bus.tr_instr, 32'h0050_0093);
        check("s_rd",      bus.tr_rd, 1);
        check("s_wd",      bus.tr_wd, 5);
        check("s_rw",      bus.tr_regwrite, 1);
        check("s_level",   level, 1);
        check("s_retired", retired_cnt, 1);
        bus.trace_ready = 1'b1;
        step();
        bus.trace_ready = 1'b0;
        check("pop_level", level, 0);
        check("pop_valid", bus.trace_valid, 0);
        check("pop_pc",    bus.tr_pc, 0);
        check("pop_instr", bus.tr_instr, 0);
        check("pop_wd",    bus.tr_wd, 0);
        check("pop_rw",    bus.tr_regwrite, 0);

        // Write to x0 is not a register write
        drive(32'h14, 32'h0000_0013, 5'd0, 32'h1234, 1'b1, 1'b0, 32'h0, 32'h0);
        step();
        bus.retire_valid = 1'b0;
        check("x0_rw", bus.tr_regwrite, 0);
        check("x0_wd", bus.tr_wd, 0);
        check("x0_pc", bus.tr_pc, 32'h14);
        bus.trace_ready = 1'b1;
        step();
        bus.trace_ready = 1'b0;

        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_retired", retired_cnt, 0);

        // Overflow: ten retires into an eight-entry FIFO with no consumer
        for (int i = 1; i <= 10; i++) begin
            drive(32'h100 + 32'(4 * i), 32'h13, 5'(i), 32'(i), 1'b1, 1'b0, 32'h0, 32'h0);
            step();
        end
        bus.retire_valid = 1'b0;
        check("ovf_level",   level, 8);
        check("ovf_drop",    drop_cnt, 2);
        check("ovf_flag",    overflow, 1);
        check("ovf_retired", retired_cnt, 10);
        step();
        check("hold_pc", bus.tr_pc, 32'h104);
        bus.trace_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_pc", bus.tr_pc, 32'h100 + 32'(4 * i));
            check("drain_wd", bus.tr_wd, 64'(i));
            step();
        end
        bus.trace_ready = 1'b0;
        check("drain_level", level, 0);
        check("ovf_sticky",  overflow, 1);

        // Full FIFO with simultaneous pop and push
        for (int i = 0; i < 8; i++) begin
            drive(32'h200 + 32'(4 * i), 32'h13, 5'd2, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            step();
        end
        check("full_level", level, 8);
        drive(32'h300, 32'h13, 5'd2, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.trace_ready = 1'b1;
        step();
        bus.retire_valid = 1'b0;
        check("pp_level",   level, 8);
        check("pp_drop",    drop_cnt, 2);
        check("pp_retired", retired_cnt, 19);
        for (int k = 0; k < 8; k++) begin
            check("pp_order", bus.tr_pc, (k < 7) ? 64'(32'h204 + 32'(4 * k)) : 64'h300);
            step();
        end
        bus.trace_ready = 1'b0;
        check("pp_empty", level, 0);

        // Clear beats a concurrent retire
        for (int i = 0; i < 5; i++) begin
            drive(32'h500 + 32'(4 * i), 32'h13, 5'd3, 32'h9, 1'b1, 1'b0, 32'h0, 32'h0);
            step();
        end
        check("pre_clr_level", level, 5);
        clr = 1'b1;
        step();
        clr = 1'b0;
        bus.retire_valid = 1'b0;
        check("clr_level",  level, 0);
        check("clr_valid",  bus.trace_valid, 0);
        check("clr_pc",     bus.tr_pc, 0);
        check("clr_cnt",    retired_cnt, 0);
        check("clr_drop",   drop_cnt, 0);
        check("clr_ovf",    overflow, 0);

        // Store record, then a non-store record
        drive(32'h600, 32'h0020_A023, 5'd0, 32'h77, 1'b0, 1'b1, 32'h2000, 32'hDEAD_BEEF);
        step();
        drive(32'h604, 32'h13, 5'd4, 32'h0, 1'b0, 1'b0, 32'h55, 32'h66);
        step();
        bus.retire_valid = 1'b0;
        check("st_maddr", bus.tr_maddr, c_EXP_MADDR);
        check("st_mdata", bus.tr_mdata, c_EXP_MDATA);
        check("st_mw",    bus.tr_memwrite, 1);
        check("st_wd",    bus.tr_wd, 0);
        bus.trace_ready = 1'b1;
        step();
        bus.trace_ready = 1'b0;
        check("ns_maddr", bus.tr_maddr, 0);
        check("ns_mdata", bus.tr_mdata, 0);
        check("ns_mw",    bus.tr_memwrite, 0);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 3; i++) begin
            drive(32'h700 + 32'(4 * i), 32'h13, 5'd5, 32'h1, 1'b1, 1'b0, 32'h0, 32'h0);
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_level",   level, 0);
        check("ar_valid",   bus.trace_valid, 0);
        check("ar_pc",      bus.tr_pc, 0);
        check("ar_wd",      bus.tr_wd, 0);
        check("ar_retired", retired_cnt, 0);
        check("ar_ovf",     overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h400, 32'h13, 5'd6, 32'h2, 1'b1, 1'b0, 32'h0, 32'h0);
        step();
        bus.retire_valid = 1'b0;
        check("post_rst_level", level, 1);
        check("post_rst_pc",    bus.tr_pc, 32'h400);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/moka_rv32i_sc_trace_fifo.md
MOKA_RV32I_SC_TRACE_FIFO -- requirements
Module: moka_rv32i_sc_trace_fifo

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_WIDTH, default 32, datapath width.
- DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, single clock; all state updates on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- clr, input, 1, synchronous clear of FIFO and counters.
- retire_valid, input, 1, core retired one instruction this cycle.
- pc, input, DATA_WIDTH, PC of the retiring instruction.
- instruction, input, DATA_WIDTH, retiring instruction word.
- rd, input, 5, destination register index.
- WD3, input, DATA_WIDTH, register-file write data.
- RegWrite, input, 1, register-file write enable.
- MemWrite, input, 1, data-memory write enable.
- ALUResult, input, DATA_WIDTH, ALU result (memory address for stores).
- RD2, input, DATA_WIDTH, store data.
- trace_valid, output, 1, head record available.
- trace_ready, input, 1, consumer accepts the head record.
- tr_pc, output, DATA_WIDTH, head record PC.
- tr_instr, output, DATA_WIDTH, head record instruction word.
- tr_rd, output, 5, head record destination register.
- tr_wd, output, DATA_WIDTH, head record write data.
- tr_regwrite, output, 1, head record register-write flag.
- tr_memwrite, output, 1, head record memory-write flag.
- tr_maddr, output, DATA_WIDTH, head record store address.
- tr_mdata, output, DATA_WIDTH, head record store data.
- level, output, $clog2(DEPTH)+1, current entry count.
- retired_cnt, output, 32, count of retire events.
- drop_cnt, output, 16, count of records lost to overflow.
- overflow, output, 1, sticky: at least one record dropped.

Function
REQ-003 Push SHALL occur on any cycle with retire_valid=1 and (level<DEPTH or pop this cycle).
REQ-004 Pop SHALL occur on any cycle with trace_valid=1 and trace_ready=1.
REQ-005 A pushed record SHALL appear on the tr_* outputs no earlier than the cycle after the push; there is no bypass.
REQ-006 trace_valid SHALL equal (level!=0).
REQ-007 All tr_* outputs SHALL be 0 while level==0.
REQ-008 While trace_valid=1 and trace_ready=0, the tr_* outputs SHALL hold stable.
REQ-009 The stored regwrite field SHALL be RegWrite and (rd!=0).
REQ-010 The stored wd field SHALL be 0 when the stored regwrite field is 0.
REQ-011 level SHALL update as follows:
- +1 on push without pop.
- -1 on pop without push.
- Unchanged on simultaneous push and pop, including when full.
REQ-012 Read and write pointers SHALL wrap modulo DEPTH.
REQ-013 Drop condition: retire_valid=1, level==DEPTH and no pop.
REQ-014 On a drop:
- The record SHALL be discarded.
- drop_cnt SHALL increment, saturating at 16'hFFFF.
- overflow SHALL set to 1.
REQ-015 retired_cnt SHALL increment on every retire_valid=1, whether pushed or dropped, and SHALL wrap at 2^32.
REQ-016 clr=1 SHALL, on that edge:
- Empty the FIFO and zero the pointers.
- Zero retired_cnt and drop_cnt.
- Clear overflow.
REQ-017 clr SHALL take priority over a push or pop in the same cycle; that retire event is not counted.

Reset
REQ-018 rst_n=0 SHALL immediately, without waiting for a clock edge:
- Set level, retired_cnt, drop_cnt and overflow to 0, and trace_valid to 0.
- Set all tr_* outputs to 0.
REQ-019 A reset asserted mid-operation SHALL discard all stored records.
REQ-020 The first push after rst_n deasserts SHALL be accepted on the first rising edge of clk.

Configuration
REQ-021 With MOKA_TRACE_MEM_EN defined, each record SHALL hold maddr=ALUResult and mdata=RD2 when MemWrite=1, and 0 otherwise.
REQ-022 Without MOKA_TRACE_MEM_EN:
- tr_maddr and tr_mdata SHALL be constant 0.
- No storage SHALL be instantiated for these fields.
- All other behaviour SHALL be unchanged.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Single record: push pc=0x00000010, instr=0x00500093, rd=1, WD3=5, RegWrite=1 -> next cycle trace_valid=1, tr_pc=0x10, tr_wd=5, tr_regwrite=1; pop with trace_ready=1 -> level=0 and all tr_*=0.
- x0 write: rd=0, RegWrite=1, WD3=0x1234 -> tr_regwrite=0 and tr_wd=0.
- Overflow: DEPTH=8, trace_ready=0, 10 consecutive retires -> level=8, drop_cnt=2, overflow=1, retired_cnt=10, and records 1..8 are drained in order.
- Full with simultaneous pop and push: level=8, trace_ready=1, retire_valid=1 -> level stays 8, drop_cnt unchanged, and the new record arrives last.
- Clear and reset: clr=1 while level=5 and retire_valid=1 -> all zero next cycle and retired_cnt=0; rst_n pulsed low mid-burst -> outputs zero before the next clk edge.
- Store, macro defined: MemWrite=1, ALUResult=0x2000, RD2=0xDEADBEEF -> tr_maddr=0x2000, tr_mdata=0xDEADBEEF; same stimulus with macro undefined -> both 0.
